// File: rtl/lcb_enable_arbiter.sv
// Purpose: gates the flop-bank LCB via lcb_en and shares it round-robin among NREQ level requesters; LCB_ARB_WDOG_EN adds a grant watchdog.
// Latency: cold grant WAKE_CYC edges after first req is sampled; warm (HOLD) and handoff grants at the sampling edge.
// Backpressure: requesters hold req until granted and done; grants are non-preemptive (unless the watchdog fires).
module lcb_enable_arbiter #(
    parameter int NREQ        = 4,
    parameter int WAKE_CYC    = 2,
    parameter int HOLD_CYC    = 8,
    parameter int MAX_GNT_CYC = 64
) (
    input  logic            iccad_clk,
    input  logic            iccad_rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            lcb_en,
    output logic            wdog_err
);

    localparam int RW   = $clog2(NREQ);
    localparam int CMAX = (WAKE_CYC > HOLD_CYC) ? WAKE_CYC : HOLD_CYC;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    if (NREQ < 2 || NREQ > 16 || WAKE_CYC < 1 || HOLD_CYC < 0 || MAX_GNT_CYC < 2) begin : g_bad_params
        $error("lcb_enable_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {OFF, WAKE, ON, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rr_q, rr_d;
    logic [RW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_d;
    logic            lcb_en_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] win;
    logic [RW-1:0]   win_idx;
    logic [RW-1:0]   rr_next;
    logic            win_vld;
    logic            fire;
    int              sidx;

    // The current grantee is excluded so a watchdog-forced release can't re-pick it.
    assign cand = elig & ~gnt;

    always_comb begin
        win     = '0;
        win_idx = '0;
        win_vld = 1'b0;
        sidx    = 0;
        // Walk backwards from the farthest slot so the nearest match to rr wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            sidx = (int'(rr_q) + k) % NREQ;
            if (cand[sidx]) begin
                win       = '0;
                win[sidx] = 1'b1;
                win_idx   = RW'(sidx);
                win_vld   = 1'b1;
            end
        end
        rr_next = (win_idx == RW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt;
        lcb_en_d = lcb_en;
        case (state_q)
            OFF: begin
                gnt_d    = '0;
                lcb_en_d = 1'b0;
                if (|elig) begin
                    state_d  = WAKE;
                    lcb_en_d = 1'b1;
                    cnt_d    = CW'(WAKE_CYC - 1);
                end
            end
            WAKE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (win_vld) begin
                    state_d = ON;
                    gnt_d   = win;
                    gidx_d  = win_idx;
                    rr_d    = rr_next;
                end else begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYC);
                end
            end
            ON: begin
                if (!req[gidx_q] || fire) begin
                    if (win_vld) begin
                        gnt_d  = win;
                        gidx_d = win_idx;
                        rr_d   = rr_next;
                    end else if (HOLD_CYC > 0) begin
                        state_d = HOLD;
                        gnt_d   = '0;
                        cnt_d   = CW'(HOLD_CYC);
                    end else begin
                        state_d  = OFF;
                        gnt_d    = '0;
                        lcb_en_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (win_vld) begin
                    state_d = ON;
                    gnt_d   = win;
                    gidx_d  = win_idx;
                    rr_d    = rr_next;
                end else if (cnt_q == '0) begin
                    state_d  = OFF;
                    lcb_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = OFF;
                gnt_d    = '0;
                lcb_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            rr_q    <= '0;
            gidx_q  <= '0;
            gnt     <= '0;
            lcb_en  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            gnt     <= gnt_d;
            lcb_en  <= lcb_en_d;
        end
    end

`ifdef LCB_ARB_WDOG_EN
    localparam int WW = $clog2(MAX_GNT_CYC);

    logic [WW-1:0]   wcnt_q;
    logic [NREQ-1:0] blk_q;
    logic            werr_q;

    assign fire     = (state_q == ON) && (wcnt_q == WW'(MAX_GNT_CYC - 1));
    assign elig     = req & ~blk_q;
    assign wdog_err = werr_q;

    // A forced-off requester stays blocked until it drops req for a cycle.
    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            wcnt_q <= '0;
            blk_q  <= '0;
            werr_q <= 1'b0;
        end else begin
            wcnt_q <= (gnt_d != gnt || gnt_d == '0) ? '0 : wcnt_q + 1'b1;
            blk_q  <= (blk_q & req) | (fire ? gnt : '0);
            if (fire) werr_q <= 1'b1;
        end
    end
`else
    assign fire     = 1'b0;
    assign elig     = req;
    assign wdog_err = 1'b0;
`endif

endmodule
